// File: rtl/lsu_if.sv
// lsu_if: word-organised memory bus between the load/store unit and memory
interface lsu_if;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_ack;
  logic [31:0] m_rdata;
  modport master(output m_req, m_we, m_addr, m_wdata, m_be, input m_ack, m_rdata);
  modport slave(input m_req, m_we, m_addr, m_wdata, m_be, output m_ack, m_rdata);
endinterface

// File: rtl/lsu.sv
// lsu: turns one CPU load/store into one word-aligned bus transaction
module lsu #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  output logic [31:0] out,
  output logic        done,
  output logic        error,
  output logic        busy,
  lsu_if.master       bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic [1:0] a_lo, sz;
  logic uns, accept, fault, timeout;
  logic [3:0] be;
  logic [31:0] wdata, shifted, ld_val;
  // next state, fault decode, lane steering and load extension
  always_comb begin
    accept = rd | we;
    fault = (rd & we) | (size == 2'b11) | (size == 2'b01 & addr[0]) | (size == 2'b10 & addr[1:0] != 2'b00);
    timeout = !bus.m_ack && cnt == CW'(TIMEOUT - 1);
    next = state == IDLE ? (accept ? (fault ? DONE : REQ) : IDLE) :
           state == REQ  ? ((bus.m_ack || timeout) ? DONE : REQ) : IDLE;
    be = size == 2'b00 ? 4'b0001 << addr[1:0] : size == 2'b01 ? 4'b0011 << addr[1:0] : 4'b1111;
    wdata = size == 2'b00 ? {4{data[7:0]}} : size == 2'b01 ? {2{data[15:0]}} : data;
    shifted = bus.m_rdata >> {a_lo, 3'b000};
    ld_val = sz == 2'b00 ? {{24{~uns & shifted[7]}}, shifted[7:0]} :
             sz == 2'b01 ? {{16{~uns & shifted[15]}}, shifted[15:0]} : shifted;
  end
  // state, registered outputs and the captured request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      a_lo <= '0;
      sz <= '0;
      uns <= 1'b0;
      out <= '0;
      done <= 1'b0;
      error <= 1'b0;
      busy <= 1'b0;
      bus.m_req <= 1'b0;
      bus.m_we <= 1'b0;
      bus.m_addr <= '0;
      bus.m_wdata <= '0;
      bus.m_be <= '0;
    end else begin
      state <= next;
      busy <= next != IDLE;
      done <= next == DONE;
      error <= next == DONE && (state == IDLE || !bus.m_ack);
      bus.m_req <= next == REQ;
      cnt <= state == REQ ? cnt + 1'b1 : '0;
      if (state == IDLE && accept) begin
        a_lo <= addr[1:0];
        sz <= size;
        uns <= unsigned_ld;
        bus.m_we <= we;
        bus.m_addr <= {addr[31:2], 2'b00};
        bus.m_be <= be;
        bus.m_wdata <= wdata;
      end
      if (state == REQ && bus.m_ack && !bus.m_we) out <= ld_val;
    end
  end
endmodule
